// File: rtl/mem_responder.sv
// Multi-cycle single-word memory target: ready pulses the cycle after edge t0+LATENCY of an accepted request.
// No backpressure: strobes are sampled only in IDLE, and rejected requests get a one-cycle err pulse.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic          legal;

  logic [31:0]   mem [DEPTH];

  // Bits above the word index only take part in the range check.
  always_comb begin
    legal = (MemRead ^ MemWrite) && (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == 32'd0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (legal) begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
            wr_d    = MemWrite;
            idx_d   = addr[AW+1:2];
            wdata_d = wdata;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a write is only committed at completion, so reset discards in-flight writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == RESP);
  assign busy  = (state_q == BUSY);
  assign err   = err_q;

endmodule
